if_fetch_queue: RTL and testbench

//  Parametrised instruction-fetch front end replacing the single PC register plus IF/ID latch.

---
 rtl/rv_fetch_pkg.sv | 17 +
 rtl/fq_storage.sv | 29 ++
 rtl/if_fetch_queue.sv | 112 +++++++++++
 tb/tb_if_fetch_queue.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/rv_fetch_pkg.sv
// Shared types for the instruction-fetch front end.
//   XLEN          : address / instruction width
//   IR_NOP        : canonical NOP (addi x0,x0,0), placed in misaligned markers
//   fetch_entry_t : one queue slot {pc, ir, misalign}
//   fq_state_t    : fetch FSM state (RUN = sequential fetch, HALT = marker queued)
package rv_fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ir;
    logic            misalign;
  } fetch_entry_t;

  typedef enum logic {FQ_RUN, FQ_HALT} fq_state_t;
endpackage

// File: rtl/fq_storage.sv
// DEPTH x fetch_entry_t register array for the fetch queue.
//   clk     : write clock
//   wr_en   : write wr_data into slot wr_addr at the rising edge
//   wr_addr : write slot
//   wr_data : entry to store
//   rd_addr : read slot (combinational read)
//   rd_data : entry held in slot rd_addr
// Contents are never reset; the pointers/count in the parent decide validity.
module fq_storage
  import rv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         wr_en,
  input  logic [AW-1:0] wr_addr,
  input  fetch_entry_t wr_data,
  input  logic [AW-1:0] rd_addr,
  output fetch_entry_t rd_data
);
  fetch_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: streams sequential fetches from IMEM into a
// DEPTH-entry queue that ID drains through a valid/ready handshake.
//   clk, reset    : clock, synchronous active-high reset
//   iad, imem_req : fetch address (= fetch_pc) and request valid
//   idt, acki_n   : fetched instruction, valid when acki_n=0
//   redirect,
//   redirect_pc   : flush queue and restart fetch at redirect_pc
//   deq_*         : head entry (valid/ready handshake with ID)
//   occupancy     : number of valid entries held
// IMEM wait states (acki_n=1) only stall the enqueue side; ID keeps draining.
// XLEN must match rv_fetch_pkg::XLEN since the entry struct comes from there.
module if_fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [XLEN-1:0]        iad,
  output logic                   imem_req,
  input  logic [XLEN-1:0]        idt,
  input  logic                   acki_n,
  input  logic                   redirect,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   deq_valid,
  input  logic                   deq_ready,
  output logic [XLEN-1:0]        deq_pc,
  output logic [XLEN-1:0]        deq_ir,
  output logic                   deq_misalign,
  output logic [$clog2(DEPTH):0] occupancy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fq_state_t       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q;
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q;
  fetch_entry_t    head, last_q, shown;
  fetch_entry_t    wr_data;
  logic [AW-1:0]   wr_addr;
  logic            wr_en, pop, push, redir_mis;

  assign deq_valid = ~reset & (count_q != '0);
  assign pop       = deq_valid & deq_ready;
  // A pop frees a slot at the same edge, so a full queue still fetches.
  assign imem_req  = ~reset & (state_q == FQ_RUN) & ~redirect &
                     ((count_q < CW'(DEPTH)) | pop);
  assign push      = imem_req & ~acki_n;
  assign redir_mis = redirect & (redirect_pc[1:0] != 2'b00);

  // A misaligned redirect writes its marker into slot 0 of the flushed queue.
  assign wr_en   = ~reset & (push | redir_mis);
  assign wr_addr = redirect ? '0 : wr_ptr_q;
  assign wr_data = redirect ? '{pc: redirect_pc, ir: IR_NOP, misalign: 1'b1}
                            : '{pc: fetch_pc_q, ir: idt, misalign: 1'b0};

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_ptr_q),
    .rd_data (head)
  );

  always_comb begin
    state_d = state_q;
    if (redirect) state_d = redir_mis ? FQ_HALT : FQ_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FQ_RUN;
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
    end else begin
      state_q <= state_d;
      // Remember what ID last saw so deq_* hold steady while empty.
      if (deq_valid) last_q <= head;
      if (redirect) begin
        rd_ptr_q   <= '0;
        wr_ptr_q   <= AW'(redir_mis);
        count_q    <= CW'(redir_mis);
        fetch_pc_q <= redirect_pc;
      end else begin
        if (push) begin
          wr_ptr_q   <= wr_ptr_q + AW'(1);
          fetch_pc_q <= fetch_pc_q + XLEN'(4);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  assign shown        = reset ? '0 : (deq_valid ? head : last_q);
  assign deq_pc       = shown.pc;
  assign deq_ir       = shown.ir;
  assign deq_misalign = shown.misalign;
  assign iad          = fetch_pc_q;
  assign occupancy    = count_q;
endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  import rv_fetch_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, redirect, acki_n, deq_ready;
  logic [31:0] redirect_pc, idt;
  logic [31:0] iad0, iad1, pc0, pc1, ir0, ir1;
  logic        req0, req1, dv0, dv1, mis0, mis1;
  logic [2:0]  occ0;
  logic [3:0]  occ1;

  int checks = 0;
  int errors = 0;

  // Two configurations: DEPTH=4 from 0, and DEPTH=8 starting near the top of memory.
  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u0 (
    .clk(clk), .reset(reset), .iad(iad0), .imem_req(req0), .idt(idt), .acki_n(acki_n),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_valid(dv0), .deq_ready(deq_ready),
    .deq_pc(pc0), .deq_ir(ir0), .deq_misalign(mis0), .occupancy(occ0));

  if_fetch_queue #(.XLEN(32), .DEPTH(8), .RESET_PC(32'hFFFF_FFF8)) u1 (
    .clk(clk), .reset(reset), .iad(iad1), .imem_req(req1), .idt(idt), .acki_n(acki_n),
    .redirect(redirect), .redirect_pc(redirect_pc), .deq_valid(dv1), .deq_ready(deq_ready),
    .deq_pc(pc1), .deq_ir(ir1), .deq_misalign(mis1), .occupancy(occ1));

  // Reference model: a plain queue of entries per instance.
  fetch_entry_t mq[2][$];
  logic [31:0]  m_fpc[2];
  bit           m_halt[2];
  fetch_entry_t m_last[2];
  int           m_dep[2] = '{4, 8};
  logic [31:0]  m_rst_pc[2] = '{32'h0000_0000, 32'hFFFF_FFF8};

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cmp(int g);
    fetch_entry_t h;
    bit dv, pop, req;
    logic [31:0] a_iad, a_pc, a_ir, a_occ;
    logic a_req, a_dv, a_mis;
    a_iad = g ? iad1 : iad0;  a_pc = g ? pc1 : pc0;  a_ir = g ? ir1 : ir0;
    a_req = g ? req1 : req0;  a_dv = g ? dv1 : dv0;  a_mis = g ? mis1 : mis0;
    a_occ = g ? 32'(occ1) : 32'(occ0);
    if (reset) begin
      chk($sformatf("u%0d.rst_req", g), 32'(a_req), 0);
      chk($sformatf("u%0d.rst_dv", g),  32'(a_dv), 0);
      chk($sformatf("u%0d.rst_pc", g),  a_pc, 0);
      chk($sformatf("u%0d.rst_ir", g),  a_ir, 0);
      chk($sformatf("u%0d.rst_mis", g), 32'(a_mis), 0);
    end else begin
      dv  = mq[g].size() > 0;
      h   = dv ? mq[g][0] : m_last[g];
      pop = dv && deq_ready;
      req = !m_halt[g] && !redirect && (mq[g].size() < m_dep[g] || pop);
      chk($sformatf("u%0d.deq_valid", g), 32'(a_dv), 32'(dv));
      chk($sformatf("u%0d.imem_req", g),  32'(a_req), 32'(req));
      chk($sformatf("u%0d.occupancy", g), a_occ, mq[g].size());
      chk($sformatf("u%0d.deq_pc", g),    a_pc, h.pc);
      chk($sformatf("u%0d.deq_ir", g),    a_ir, h.ir);
      chk($sformatf("u%0d.deq_mis", g),   32'(a_mis), 32'(h.misalign));
      if (!m_halt[g]) chk($sformatf("u%0d.iad", g), a_iad, m_fpc[g]);
    end
  endtask

  task automatic upd(int g);
    fetch_entry_t h;
    bit dv, pop, req;
    if (reset) begin
      mq[g].delete();
      m_fpc[g]  = m_rst_pc[g];
      m_halt[g] = 0;
      m_last[g] = '0;
      return;
    end
    dv  = mq[g].size() > 0;
    h   = dv ? mq[g][0] : m_last[g];
    pop = dv && deq_ready;
    req = !m_halt[g] && !redirect && (mq[g].size() < m_dep[g] || pop);
    if (dv) m_last[g] = h;
    if (redirect) begin
      mq[g].delete();
      m_fpc[g] = redirect_pc;
      if (redirect_pc[1:0] == 2'b00) m_halt[g] = 0;
      else begin
        mq[g].push_back('{pc: redirect_pc, ir: 32'h13, misalign: 1'b1});
        m_halt[g] = 1;
      end
    end else begin
      if (pop) void'(mq[g].pop_front());
      if (req && !acki_n) begin
        mq[g].push_back('{pc: m_fpc[g], ir: idt, misalign: 1'b0});
        m_fpc[g] = m_fpc[g] + 32'd4;
      end
    end
  endtask

  // One clock: drive inputs, check outputs before the edge, advance the model.
  task automatic cyc(bit r, bit red, logic [31:0] rpc, bit an, bit rdy);
    reset = r; redirect = red; redirect_pc = rpc; acki_n = an; deq_ready = rdy;
    idt = $urandom;
    #1;
    cmp(0); cmp(1);
    @(posedge clk);
    upd(0); upd(1);
    #1;
  endtask

  initial begin
    logic [31:0] rpc;
    int rdy_pct;
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk("lit.u0_iad_reset", iad0, 32'h0);
    chk("lit.u1_iad_reset", iad1, 32'hFFFF_FFF8);
    chk("lit.u0_occ_reset", 32'(occ0), 0);

    // Fill DEPTH=4 queue with ID stalled.
    cyc(0, 0, 0, 0, 0);
    chk("lit.u1_iad_wrap1", iad1, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    chk("lit.u1_iad_wrap2", iad1, 32'h0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit.full_occ", 32'(occ0), 4);
    chk("lit.full_iad", iad0, 32'h10);
    chk("lit.full_req", 32'(req0), 0);
    chk("lit.full_head", pc0, 32'h0);

    // Full queue, pop and push on the same edge.
    cyc(0, 0, 0, 0, 1);
    chk("lit.pp_occ", 32'(occ0), 4);
    chk("lit.pp_head", pc0, 32'h4);
    chk("lit.pp_iad", iad0, 32'h14);

    // IMEM wait states mid-stream.
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("lit.wait_iad", iad0, 32'h8);
    chk("lit.wait_occ", 32'(occ0), 2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("lit.order%0d", k), pc0, 32'(k * 4));
      cyc(0, 0, 0, 1, 1);
    end
    chk("lit.drained_dv", 32'(dv0), 0);

    // Redirect with 3 entries queued and ID ready.
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0);
    chk("lit.pre_redir_occ", 32'(occ0), 3);
    cyc(0, 1, 32'h100, 0, 1);
    chk("lit.redir_occ", 32'(occ0), 0);
    chk("lit.redir_dv", 32'(dv0), 0);
    chk("lit.redir_iad", iad0, 32'h100);
    cyc(0, 0, 0, 0, 0);
    chk("lit.redir_head", pc0, 32'h100);

    // Misaligned redirect, then recovery.
    cyc(0, 1, 32'h102, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chk("lit.mis_dv", 32'(dv0), 1);
    chk("lit.mis_pc", pc0, 32'h102);
    chk("lit.mis_ir", ir0, 32'h13);
    chk("lit.mis_flag", 32'(mis0), 1);
    chk("lit.mis_req", 32'(req0), 0);
    chk("lit.mis_occ", 32'(occ0), 1);
    cyc(0, 1, 32'h200, 0, 1);
    chk("lit.resume_iad", iad0, 32'h200);
    cyc(0, 0, 0, 0, 0);
    chk("lit.resume_head", pc0, 32'h200);
    chk("lit.resume_mis", 32'(mis0), 0);

    // Randomised traffic with phases of different ID back-pressure.
    rdy_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) rdy_pct = $urandom_range(5, 95);
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFF0;
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 24) == 0, rpc,
          $urandom_range(0, 2) == 0, $urandom_range(0, 99) < rdy_pct);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
